// File: rtl/lstm_seq_ctrl.sv
// Timestep sequencer for the LSTM input-vector memory: issues addr 0..N-1 to the
// cell with a valid/ready handshake, optionally followed by a reverse sweep.
module lstm_seq_ctrl #(
  parameter int WIDTH          = 32,
  parameter int NUM_ITERATIONS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bptt_en,
  output logic [WIDTH-1:0] addr,
  output logic             x_valid,
  input  logic             x_ready,
  input  logic             step_done,
  output logic             h_clr,
  output logic             dir,
  output logic             t_first,
  output logic             t_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, TURN, FIN} state_t;

  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(NUM_ITERATIONS - 1);

  state_t           state_reg, state_next;
  logic             bptt_reg, bptt_next;
  logic [WIDTH-1:0] addr_next;
  logic             x_valid_next, h_clr_next, dir_next;
  logic             t_first_next, t_last_next, busy_next, done_next;
  logic             sweep_end;

  // End of the current sweep depends on direction: top going up, zero coming down.
  assign sweep_end = dir ? (addr == '0) : (addr == LAST_ADDR);

  always_comb begin
    state_next   = state_reg;
    bptt_next    = bptt_reg;
    addr_next    = addr;
    dir_next     = dir;
    busy_next    = busy;
    x_valid_next = 1'b0;
    h_clr_next   = 1'b0;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          bptt_next  = bptt_en;
          state_next = CLR;
          h_clr_next = 1'b1;
          addr_next  = '0;
          dir_next   = 1'b0;
          busy_next  = 1'b1;
        end
      end
      CLR: begin
        state_next   = ISSUE;
        x_valid_next = 1'b1;
      end
      ISSUE: begin
        if (x_valid && x_ready) begin
          state_next = WAIT;
        end else begin
          x_valid_next = 1'b1;
        end
      end
      WAIT: begin
        if (step_done) begin
          if (!sweep_end) begin
            addr_next    = dir ? (addr - 1'b1) : (addr + 1'b1);
            state_next   = ISSUE;
            x_valid_next = 1'b1;
          end else if (!dir && bptt_reg) begin
            state_next = TURN;
            dir_next   = 1'b1;
          end else begin
            state_next = FIN;
            done_next  = 1'b1;
          end
        end
      end
      TURN: begin
        state_next   = ISSUE;
        x_valid_next = 1'b1;
      end
      FIN: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        addr_next  = '0;
        dir_next   = 1'b0;
        bptt_next  = 1'b0;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        addr_next  = '0;
        dir_next   = 1'b0;
      end
    endcase

    // Position flags are registered alongside addr/dir so they line up with x_valid.
    t_first_next = (state_next != IDLE) &&
                   (dir_next ? (addr_next == LAST_ADDR) : (addr_next == '0));
    t_last_next  = (state_next != IDLE) &&
                   (dir_next ? (addr_next == '0) : (addr_next == LAST_ADDR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      bptt_reg  <= 1'b0;
      addr      <= '0;
      x_valid   <= 1'b0;
      h_clr     <= 1'b0;
      dir       <= 1'b0;
      t_first   <= 1'b0;
      t_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      bptt_reg  <= bptt_next;
      addr      <= addr_next;
      x_valid   <= x_valid_next;
      h_clr     <= h_clr_next;
      dir       <= dir_next;
      t_first   <= t_first_next;
      t_last    <= t_last_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: directed sequence against an N=8 and an N=1 instance,
// with handshakes scored against a queue of expected timesteps.
module tb_lstm_seq_ctrl;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] addr;
    logic         dir;
    logic         tf;
    logic         tl;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, start1 = 1'b0, bptt_en = 1'b0;
  logic x_ready = 1'b1, step_done = 1'b0, x_ready1 = 1'b1, step_done1 = 1'b0;
  logic [W-1:0] addr, addr1;
  logic x_valid, h_clr, dir, t_first, t_last, busy, done;
  logic x_valid1, h_clr1, dir1, t_first1, t_last1, busy1, done1;

  int n_checks = 0, n_pass = 0;
  exp_t q8[$], q1[$];
  logic [W-1:0] stall_addr = '1;
  int stall_left = 0, stall_seen = 0, stall_first = 0, stall_last = 0;
  bit spur_sd = 1'b0;
  int cyc_ctr = 0, cnt_hclr = 0, cnt_done = 0, cnt_hs = 0, cnt_hs1 = 0, cnt_done1 = 0;
  bit hs_pend = 1'b0, hs_pend1 = 1'b0, sd_prev = 1'b0;

  lstm_seq_ctrl #(.WIDTH(W), .NUM_ITERATIONS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .bptt_en(bptt_en), .addr(addr),
    .x_valid(x_valid), .x_ready(x_ready), .step_done(step_done), .h_clr(h_clr),
    .dir(dir), .t_first(t_first), .t_last(t_last), .busy(busy), .done(done)
  );

  lstm_seq_ctrl #(.WIDTH(W), .NUM_ITERATIONS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bptt_en(bptt_en), .addr(addr1),
    .x_valid(x_valid1), .x_ready(x_ready1), .step_done(step_done1), .h_clr(h_clr1),
    .dir(dir1), .t_first(t_first1), .t_last(t_last1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic hs_check(input string p, input exp_t e, input logic [W-1:0] a,
                          input logic d, input logic tf, input logic tl);
    $display("%s handshake addr=%0d dir=%0b t_first=%0b t_last=%0b", p, a, d, tf, tl);
    check({p, "_addr"}, a, e.addr);
    check({p, "_dir"}, W'(d), W'(e.dir));
    check({p, "_t_first"}, W'(tf), W'(e.tf));
    check({p, "_t_last"}, W'(tl), W'(e.tl));
  endtask

  // Cell model for the N=8 instance: optional stall, step_done one cycle after each handshake.
  always @(negedge clk) begin
    exp_t e;
    cyc_ctr++;
    if (!rst_n) begin
      step_done = 1'b0;
      x_ready   = 1'b1;
      hs_pend   = 1'b0;
      sd_prev   = 1'b0;
    end else begin
      sd_prev   = step_done;
      step_done = hs_pend;
      hs_pend   = 1'b0;
      if (x_valid && addr == stall_addr && stall_left > 0) begin
        x_ready = 1'b0;
        if (stall_seen == 0) stall_first = cyc_ctr;
        stall_last = cyc_ctr;
        stall_left--;
        stall_seen++;
        if (spur_sd) step_done = 1'b1;
      end else begin
        x_ready = 1'b1;
      end
      if (x_valid && x_ready) begin
        cnt_hs++;
        e = (q8.size() > 0) ? q8.pop_front() : '1;
        hs_check("n8", e, addr, dir, t_first, t_last);
        hs_pend = 1'b1;
      end
      if (h_clr) cnt_hclr++;
      if (done) begin
        cnt_done++;
        check("done_follows_step_done", W'(sd_prev), W'(1));
      end
    end
  end

  // Cell model for the N=1 instance: always ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      step_done1 = 1'b0;
      hs_pend1   = 1'b0;
    end else begin
      step_done1 = hs_pend1;
      hs_pend1   = 1'b0;
      if (x_valid1 && x_ready1) begin
        cnt_hs1++;
        e = (q1.size() > 0) ? q1.pop_front() : '1;
        hs_check("n1", e, addr1, dir1, t_first1, t_last1);
        hs_pend1 = 1'b1;
      end
      if (done1) cnt_done1++;
    end
  end

  task automatic check_idle(input string p);
    check({p, "_addr"}, addr, '0);
    check({p, "_x_valid"}, W'(x_valid), '0);
    check({p, "_h_clr"}, W'(h_clr), '0);
    check({p, "_dir"}, W'(dir), '0);
    check({p, "_t_first"}, W'(t_first), '0);
    check({p, "_t_last"}, W'(t_last), '0);
    check({p, "_busy"}, W'(busy), '0);
    check({p, "_done"}, W'(done), '0);
  endtask

  task automatic push_seq(input bit bptt);
    for (int i = 0; i < 8; i++) q8.push_back('{W'(i), 1'b0, i == 0, i == 7});
    if (bptt) for (int i = 7; i >= 0; i--) q8.push_back('{W'(i), 1'b1, i == 7, i == 0});
  endtask

  // Runs one full sequence on the N=8 instance; spur_cyc pulses start mid-run,
  // poke_fin pulses start during the FIN cycle.
  task automatic run_seq(input string p, input bit bptt, input bit poke_fin, input int spur_cyc);
    int cyc;
    push_seq(bptt);
    cnt_hclr = 0; cnt_done = 0; cnt_hs = 0;
    bptt_en = bptt; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bptt_en = 1'b0;
    check({p, "_clr_h_clr"}, W'(h_clr), W'(1));
    check({p, "_clr_busy"}, W'(busy), W'(1));
    check({p, "_clr_x_valid"}, W'(x_valid), '0);
    @(negedge clk);
    check({p, "_issue_x_valid"}, W'(x_valid), W'(1));
    check({p, "_issue_addr"}, addr, '0);
    check({p, "_issue_t_first"}, W'(t_first), W'(1));
    cyc = 0;
    while (!done && cyc < 300) begin
      start = (cyc == spur_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({p, "_done_seen"}, W'(done), W'(1));
    check({p, "_fin_busy"}, W'(busy), W'(1));
    if (poke_fin) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_idle({p, "_post"});
    @(negedge clk);
    check({p, "_stay_idle_busy"}, W'(busy), '0);
    check({p, "_stay_idle_h_clr"}, W'(h_clr), '0);
    check({p, "_n_hclr"}, W'(cnt_hclr), W'(1));
    check({p, "_n_done"}, W'(cnt_done), W'(1));
    check({p, "_n_hs"}, W'(cnt_hs), bptt ? W'(16) : W'(8));
    check({p, "_queue_empty"}, W'(q8.size()), '0);
    $display("%s sequence complete: handshakes=%0d h_clr=%0d done=%0d", p, cnt_hs, cnt_hclr, cnt_done);
  endtask

  initial begin
    int cyc;
    bit found;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_busy1", W'(busy1), '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq("fwd", 1'b0, 1'b0, -1);
    run_seq("bptt", 1'b1, 1'b0, -1);

    stall_addr = W'(3); stall_left = 5; stall_seen = 0;
    run_seq("stall", 1'b0, 1'b0, -1);
    check("stall_cycles", W'(stall_seen), W'(5));
    check("stall_contiguous", W'(stall_last - stall_first), W'(4));

    stall_addr = W'(2); stall_left = 3; stall_seen = 0; spur_sd = 1'b1;
    run_seq("spur", 1'b0, 1'b1, 5);
    spur_sd = 1'b0; stall_addr = '1;

    // Reset while waiting for step_done at addr 5.
    for (int i = 0; i < 6; i++) q8.push_back('{W'(i), 1'b0, i == 0, 1'b0});
    bptt_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      found = busy && !x_valid && !h_clr && addr == W'(5);
    end
    check("reach_wait5", W'(found), W'(1));
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    check("async_rst_queue", W'(q8.size()), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq("after_rst", 1'b0, 1'b0, -1);

    // Single-timestep sequence with reverse sweep.
    q1.push_back('{W'(0), 1'b0, 1'b1, 1'b1});
    q1.push_back('{W'(0), 1'b1, 1'b1, 1'b1});
    cnt_hs1 = 0; cnt_done1 = 0;
    bptt_en = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; bptt_en = 1'b0;
    check("n1_clr_h_clr", W'(h_clr1), W'(1));
    cyc = 0;
    while (!done1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("n1_done_seen", W'(done1), W'(1));
    @(negedge clk);
    check("n1_post_busy", W'(busy1), '0);
    check("n1_n_hs", W'(cnt_hs1), W'(2));
    check("n1_n_done", W'(cnt_done1), W'(1));
    check("n1_queue_empty", W'(q1.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
